// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: one-hot column drive, synchronized row sampling at slot ends,
// per-key debounce, release tracking and a single-entry key holding register.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       key_ack,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       overrun
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_RELEASE  = 2'd2;

  logic [3:0]    r1_q, rsync_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    colidx_q, colidx_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic          slot_end;
  logic          single;
  logic [1:0]    ridx;
  logic          cand_match;

  assign slot_end   = (div_q == DW'(SCAN_DIV - 1));
  assign cand_match = (rsync_q == (4'b0001 << cand_q));

  always_comb begin
    single = 1'b1;
    ridx   = 2'd0;
    case (rsync_q)
      4'b0001: ridx = 2'd0;
      4'b0010: ridx = 2'd1;
      4'b0100: ridx = 2'd2;
      4'b1000: ridx = 2'd3;
      default: single = 1'b0;
    endcase
  end

  always_comb begin
    div_d    = slot_end ? '0 : div_q + DW'(1);
    colidx_d = colidx_q;
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;

    if (valid_q && key_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end

    case (state_q)
      ST_SCAN: begin
        if (slot_end) begin
          if (single) begin
            cand_d  = ridx;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            colidx_d = colidx_q + 2'd1;
          end
        end
      end
      ST_DEBOUNCE: begin
        // Key delivery happens the cycle after the final confirming sample, not at a slot end.
        if (cnt_q == 4'(DEBOUNCE_CNT)) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
          if (valid_q && !key_ack) begin
            ovr_d = 1'b1;
          end else begin
            code_d  = {cand_q, colidx_q};
            valid_d = 1'b1;
            ovr_d   = 1'b0;
          end
        end else if (slot_end) begin
          if (cand_match) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d    = '0;
            colidx_d = colidx_q + 2'd1;
            state_d  = ST_SCAN;
          end
        end
      end
      ST_RELEASE: begin
        if (slot_end) begin
          if (rsync_q == 4'b0000) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE_CNT)) begin
              cnt_d    = '0;
              colidx_d = colidx_q + 2'd1;
              state_d  = ST_SCAN;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_q     <= '0;
      rsync_q  <= '0;
      div_q    <= '0;
      colidx_q <= '0;
      state_q  <= ST_SCAN;
      cand_q   <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      r1_q     <= row;
      rsync_q  <= r1_q;
      div_q    <= div_d;
      colidx_q <= colidx_d;
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign col       = 4'b1000 >> colidx_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=2) with a per-column keypad
// model and a queue of expected key codes.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_ack;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;

  logic [3:0] keymap [4];
  logic [3:0] exp_q [$];
  int total = 0;
  int bad   = 0;
  int n     = 0;

  localparam int N0 = 32;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .key_ack  (key_ack),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // Pressed keys connect the driven column to their row line.
  always_comb begin
    row = '0;
    case (col)
      4'b1000: row = keymap[0];
      4'b0100: row = keymap[1];
      4'b0010: row = keymap[2];
      4'b0001: row = keymap[3];
      default: row = '0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic go_to(input int t);
    while (n < t) step();
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, key_code, e);
    end
  endtask

  function automatic logic [3:0] col_at(input int k);
    return 4'b1000 >> ((k / 4) % 4);
  endfunction

  initial begin
    reset   = 1'b1;
    key_ack = 1'b0;
    foreach (keymap[i]) keymap[i] = '0;

    @(negedge clk);
    chk("rst_col", col, 4'b1000);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_ovr", overrun, 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;

    // Idle scan: each column held four clocks, wrapping back to 1000.
    for (int k = 0; k <= 16; k++) begin
      go_to(k);
      chk("scan_col", col, col_at(k));
      chk("scan_valid", key_valid, 0);
    end

    // Steady key at row 2 / col 0010.
    go_to(N0);
    keymap[2] = 4'b0100;
    exp_q.push_back(4'b1010);
    go_to(N0 + 12); chk("k1_col_frozen", col, 4'b0010);
    go_to(N0 + 20); chk("k1_not_yet", key_valid, 0);
    chk("k1_col_held", col, 4'b0010);
    go_to(N0 + 21); chk("k1_valid", key_valid, 1);
    pop_check("k1_code");
    chk("k1_ovr", overrun, 0);
    keymap[2] = '0;
    go_to(N0 + 27); chk("rel1_col_held", col, 4'b0010);
    go_to(N0 + 28); chk("rel1_col_adv", col, 4'b0001);

    // Second key while the first is unacknowledged: dropped with overrun.
    keymap[3] = 4'b0001;
    go_to(N0 + 40); chk("ovr_not_yet", overrun, 0);
    go_to(N0 + 41); chk("ovr_set", overrun, 1);
    chk("ovr_code_kept", key_code, 4'b1010);
    chk("ovr_valid", key_valid, 1);
    key_ack = 1'b1;
    go_to(N0 + 42);
    key_ack = 1'b0;
    chk("ack_valid", key_valid, 0);
    chk("ack_ovr", overrun, 0);
    keymap[3] = '0;
    go_to(N0 + 51); chk("rel2_col_held", col, 4'b0001);
    go_to(N0 + 52); chk("rel2_col_adv", col, 4'b1000);

    // Ghosting: two rows at once is ignored.
    keymap[0] = 4'b0011;
    go_to(N0 + 55); chk("ghost_col", col, 4'b1000);
    go_to(N0 + 56); chk("ghost_adv", col, 4'b0100);
    chk("ghost_valid", key_valid, 0);
    go_to(N0 + 64); chk("ghost_scan", col, 4'b0001);
    keymap[0] = '0;

    // Bounce: key gone after the first sample.
    go_to(N0 + 68); chk("bnc_start", col, 4'b1000);
    keymap[2] = 4'b0100;
    go_to(N0 + 76); chk("bnc_col", col, 4'b0010);
    go_to(N0 + 80); chk("bnc_hold", col, 4'b0010);
    keymap[2] = '0;
    go_to(N0 + 83); chk("bnc_last", col, 4'b0010);
    go_to(N0 + 84); chk("bnc_adv", col, 4'b0001);
    chk("bnc_valid", key_valid, 0);

    // Reset while debouncing.
    go_to(N0 + 88);
    keymap[1] = 4'b1000;
    go_to(N0 + 96); chk("deb_hold", col, 4'b0100);
    go_to(N0 + 97);
    reset = 1'b1;
    keymap[1] = '0;
    #1;
    chk("mrst_col", col, 4'b1000);
    chk("mrst_valid", key_valid, 0);
    chk("mrst_ovr", overrun, 0);
    step();
    step();
    reset = 1'b0;
    n = 0;

    keymap[2] = 4'b0001;
    exp_q.push_back(4'b0010);
    for (int k = 0; k <= 7; k++) begin
      go_to(k);
      chk("post_rst_col", col, col_at(k));
    end
    while (!key_valid && n < 60) step();
    chk("k2_valid", key_valid, 1);
    chk("k2_latency", n, 21);
    pop_check("k2_code");
    key_ack = 1'b1;
    step();
    key_ack = 1'b0;
    chk("k2_ack", key_valid, 0);
    keymap[2] = '0;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each column is driven; legal values are 4 or more.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4, giving the consecutive confirming samples required; legal values are 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port row, input, 4 bits: keypad row lines, active-high, asynchronous to clk.
REQ-006 SHALL have port key_ack, input, 1 bit: consumer acknowledge of key_code.
REQ-007 SHALL have port col, output, 4 bits: one-hot, active-high column drive.
REQ-008 SHALL have port key_code, output, 4 bits: [3:2] is the row index, [1:0] is the column index.
REQ-009 SHALL have port key_valid, output, 1 bit: high while key_code holds an unacknowledged key.
REQ-010 SHALL have port overrun, output, 1 bit: high when a key was dropped while key_valid was high.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value rsync.
REQ-012 SHALL define scan order and column index as: index 0 = col 4'b1000, 1 = 4'b0100, 2 = 4'b0010, 3 = 4'b0001, then wrap to index 0.
REQ-013 SHALL count SCAN_DIV cycles per slot with a divider; a "sample" is rsync taken in the last cycle of a slot (divider = SCAN_DIV-1).
REQ-014 SHALL define row index n as rsync bit n.
REQ-015 SHALL implement states SCAN, DEBOUNCE and RELEASE.
REQ-016 SCAN: sample equal to 0 -> advance col at the slot end.
REQ-017 SCAN: sample with more than one bit set (ghosting) -> treat as 0 and advance col.
REQ-018 SCAN: sample with exactly one bit set -> latch the candidate {row index, column index}, hold col, enter DEBOUNCE.
REQ-019 DEBOUNCE: col held; each sample equal to the candidate row increments a match counter.
REQ-020 DEBOUNCE: the first mismatching sample -> clear the counter, advance col, return to SCAN.
REQ-021 DEBOUNCE: when the counter reaches DEBOUNCE_CNT, in the cycle after that sample SHALL: load key_code, set key_valid, enter RELEASE.
REQ-022 DEBOUNCE: if key_valid is already high when the counter reaches DEBOUNCE_CNT, key_code SHALL be left unchanged, overrun set, and RELEASE entered.
REQ-023 RELEASE: col held; DEBOUNCE_CNT consecutive samples of 0 -> advance col, enter SCAN.
REQ-024 RELEASE: any nonzero sample clears the zero counter; no new key is reported in RELEASE.
REQ-025 key_valid and key_code SHALL remain stable until a rising edge with key_valid=1 and key_ack=1; that edge clears key_valid and overrun.
REQ-026 key_ack SHALL be ignored while key_valid=0.
REQ-027 A new key load and an ack on the same edge: the load SHALL win (key_valid stays 1, new key_code, overrun cleared).
REQ-028 The divider SHALL run continuously; state changes SHALL occur only at slot ends, except the key load defined in REQ-021.
REQ-029 col SHALL always be exactly one-hot, including immediately after reset.

Reset
REQ-030 On reset high SHALL immediately set: col=4'b1000, state SCAN, key_code=4'b0000, key_valid=0, overrun=0, all counters=0, synchronizer flops=0.
REQ-031 Reset asserted mid-DEBOUNCE or mid-RELEASE SHALL discard the candidate; scanning restarts at index 0 with a full SCAN_DIV slot after release.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2)
REQ-032 Reset then row=0: col cycles 1000 -> 0100 -> 0010 -> 0001 -> 1000, each held exactly 4 clocks; key_valid stays 0.
REQ-033 Drive row=4'b0100 whenever col=0010, held steady: col freezes at 0010; after 3 samples key_code=4'b1010 and key_valid=1.
REQ-034 Same stimulus but row drops to 0 after the first sample: no key_valid; col advances to 0001 at the next slot end.
REQ-035 row=4'b0011 during col=1000: treated as ghosting, no key detected, scan continues normally.
REQ-036 Key held, then released and pressed again as 4'b0001 at col=0001 without an ack: key_code stays 4'b1010 and overrun=1; pulse key_ack for one cycle -> key_valid=0 and overrun=0.
REQ-037 Assert reset during DEBOUNCE: col=1000, key_valid=0 immediately; normal scanning resumes after reset release.
